// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: decode-side jump, checkpoint and flush signals for the return-address stack.
interface return_addr_stack_if #(
    parameter int WIDTH = 32,
    parameter int CKW   = 2
);
    logic             clk_en;
    logic             valid;
    logic             is_jalr;
    logic [WIDTH-1:0] pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [WIDTH-1:0] address_out;
    logic             empty;
    logic             ckpt_alloc;
    logic [CKW-1:0]   ckpt_id;
    logic             ckpt_full;
    logic             ckpt_release;
    logic             flush_valid;
    logic [CKW-1:0]   flush_id;
    modport master (
        output clk_en, valid, is_jalr, pc, rd, rs1, ckpt_alloc, ckpt_release, flush_valid, flush_id,
        input  address_out, empty, ckpt_id, ckpt_full
    );
    modport slave (
        input  clk_en, valid, is_jalr, pc, rd, rs1, ckpt_alloc, ckpt_release, flush_valid, flush_id,
        output address_out, empty, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/return_addr_stack.sv
// return_addr_stack: checkpointed return-address stack with RISC-V link hints and flush recovery.
// Define RAS_TOP_RESTORE_EN to also snapshot and restore the top-of-stack entry on flush.
module return_addr_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int NCKPT = 4
) (
    input logic clk,
    input logic rst,
    return_addr_stack_if.slave bus
);
    localparam int DW  = $clog2(DEPTH);
    localparam int CKW = $clog2(NCKPT);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    tos_q, tos_d;
    logic [DW:0]      count_q, count_d;
    logic [CKW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CKW:0]     occ_q, occ_d;
    logic [DW-1:0]    slot_tos_q [NCKPT];
    logic [DW-1:0]    slot_tos_d [NCKPT];
    logic [DW:0]      slot_cnt_q [NCKPT];
    logic [DW:0]      slot_cnt_d [NCKPT];
`ifdef RAS_TOP_RESTORE_EN
    logic [WIDTH-1:0] slot_top_q [NCKPT];
    logic [WIDTH-1:0] slot_top_d [NCKPT];
`endif

    logic             link_rd, link_rs1, op_en, do_push, do_pop, do_pp, rel, alloc_ok;
    logic [WIDTH-1:0] ret;
    logic [DW-1:0]    op_tos;
    logic [DW:0]      op_cnt;
    logic [CKW-1:0]   fdiff;

    assign bus.address_out = stack_q[tos_q];
    assign bus.empty       = count_q == '0;
    assign bus.ckpt_id     = tail_q;
    assign bus.ckpt_full   = occ_q == (CKW+1)'(NCKPT);

    always_comb begin
        link_rd  = bus.rd == 5'd1 || bus.rd == 5'd5;
        link_rs1 = bus.rs1 == 5'd1 || bus.rs1 == 5'd5;
        op_en    = bus.valid && !bus.flush_valid;
        do_push  = op_en && link_rd && (!bus.is_jalr || !link_rs1 || bus.rd == bus.rs1);
        do_pop   = op_en && bus.is_jalr && !link_rd && link_rs1;
        do_pp    = op_en && bus.is_jalr && link_rd && link_rs1 && bus.rd != bus.rs1;
        ret      = bus.pc + WIDTH'(4);
        rel      = bus.ckpt_release && occ_q != '0;
        // A release in the same cycle frees the head slot, so a full ring can still accept the alloc.
        alloc_ok = bus.ckpt_alloc && !bus.flush_valid && (!bus.ckpt_full || rel);
        op_tos   = do_push ? tos_q + DW'(1) :
                   (do_pop && count_q != '0) ? tos_q - DW'(1) : tos_q;
        op_cnt   = do_push ? (count_q == (DW+1)'(DEPTH) ? count_q : count_q + (DW+1)'(1)) :
                   (do_pop && count_q != '0) ? count_q - (DW+1)'(1) :
                   (do_pp && count_q == '0) ? (DW+1)'(1) : count_q;
        stack_d    = stack_q;
        slot_tos_d = slot_tos_q;
        slot_cnt_d = slot_cnt_q;
`ifdef RAS_TOP_RESTORE_EN
        slot_top_d = slot_top_q;
`endif
        if (do_push || do_pp) stack_d[op_tos] = ret;
        tos_d  = op_tos;
        count_d = op_cnt;
        head_d = head_q + CKW'(rel);
        fdiff  = bus.flush_id - head_q;
        if (bus.flush_valid) begin
            tos_d   = slot_tos_q[bus.flush_id];
            count_d = slot_cnt_q[bus.flush_id];
`ifdef RAS_TOP_RESTORE_EN
            stack_d[slot_tos_q[bus.flush_id]] = slot_top_q[bus.flush_id];
`endif
            tail_d = bus.flush_id + CKW'(1);
            occ_d  = {1'b0, fdiff} + (CKW+1)'(1) - (CKW+1)'(rel);
        end else begin
            tail_d = tail_q + CKW'(alloc_ok);
            occ_d  = occ_q + (CKW+1)'(alloc_ok) - (CKW+1)'(rel);
        end
        if (alloc_ok) begin
            slot_tos_d[tail_q] = op_tos;
            slot_cnt_d[tail_q] = op_cnt;
`ifdef RAS_TOP_RESTORE_EN
            slot_top_d[tail_q] = stack_d[op_tos];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
            for (int i = 0; i < NCKPT; i++) begin
                slot_tos_q[i] <= '0;
                slot_cnt_q[i] <= '0;
`ifdef RAS_TOP_RESTORE_EN
                slot_top_q[i] <= '0;
`endif
            end
            tos_q   <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
        end else if (bus.clk_en) begin
            stack_q    <= stack_d;
            slot_tos_q <= slot_tos_d;
            slot_cnt_q <= slot_cnt_d;
`ifdef RAS_TOP_RESTORE_EN
            slot_top_q <= slot_top_d;
`endif
            tos_q   <= tos_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
        end
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed checks of push/pop classification, overflow, checkpoints, flush and reset.
module tb_return_addr_stack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    return_addr_stack_if #(.WIDTH(32), .CKW(2)) ras_if();
    return_addr_stack dut (.clk(clk), .rst(rst), .bus(ras_if));

    always #5 clk = ~clk;

    task automatic idle();
        ras_if.clk_en       = 1'b1;
        ras_if.valid        = 1'b0;
        ras_if.is_jalr      = 1'b0;
        ras_if.pc           = '0;
        ras_if.rd           = '0;
        ras_if.rs1          = '0;
        ras_if.ckpt_alloc   = 1'b0;
        ras_if.ckpt_release = 1'b0;
        ras_if.flush_valid  = 1'b0;
        ras_if.flush_id     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic jump(input logic jalr, input logic [31:0] p, input logic [4:0] d, input logic [4:0] s);
        ras_if.valid   = 1'b1;
        ras_if.is_jalr = jalr;
        ras_if.pc      = p;
        ras_if.rd      = d;
        ras_if.rs1     = s;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ras_if.address_out !== 32'h0) $display("FAIL reset_addr got %h exp %h", ras_if.address_out, 32'h0); else passed++;
        total++; if (ras_if.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", ras_if.empty); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd0) $display("FAIL reset_ckpt_id got %0d exp 0", ras_if.ckpt_id); else passed++;
        total++; if (ras_if.ckpt_full !== 1'b0) $display("FAIL reset_ckpt_full got %b exp 0", ras_if.ckpt_full); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        jump(1'b0, 32'h100, 5'd1, 5'd0); step(); idle();
        total++; if (ras_if.address_out !== 32'h104) $display("FAIL basic_push_addr got %h exp %h", ras_if.address_out, 32'h104); else passed++;
        total++; if (ras_if.empty !== 1'b0) $display("FAIL basic_push_empty got %b exp 0", ras_if.empty); else passed++;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL basic_pop_empty got %b exp 1", ras_if.empty); else passed++;
        jump(1'b0, 32'h100, 5'd2, 5'd0); step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL basic_jal_nolink got %b exp 1", ras_if.empty); else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            jump(1'b0, 32'(i * 16), 5'd5, 5'd0); step();
        end
        idle();
        total++; if (ras_if.address_out !== 32'h84) $display("FAIL ovf_top got %h exp %h", ras_if.address_out, 32'h84); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (ras_if.address_out !== 32'(32'h84 - i * 16)) $display("FAIL ovf_pop%0d got %h exp %h", i, ras_if.address_out, 32'(32'h84 - i * 16)); else passed++;
            jump(1'b1, 32'h0, 5'd0, 5'd5); step();
        end
        idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL ovf_drained_empty got %b exp 1", ras_if.empty); else passed++;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL ovf_pop_empty got %b exp 1", ras_if.empty); else passed++;
        total++; if (ras_if.address_out !== 32'h84) $display("FAIL ovf_pop_empty_addr got %h exp %h", ras_if.address_out, 32'h84); else passed++;
    endtask

    task automatic test_pop_then_push();
        do_reset();
        jump(1'b0, 32'h100, 5'd1, 5'd0); step();
        jump(1'b1, 32'h200, 5'd1, 5'd5); #1;
        total++; if (ras_if.address_out !== 32'h104) $display("FAIL pp_same_cycle got %h exp %h", ras_if.address_out, 32'h104); else passed++;
        step(); idle();
        total++; if (ras_if.address_out !== 32'h204) $display("FAIL pp_next got %h exp %h", ras_if.address_out, 32'h204); else passed++;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL pp_count got empty %b exp 1", ras_if.empty); else passed++;
        jump(1'b1, 32'h300, 5'd5, 5'd5); step(); idle();
        total++; if (ras_if.address_out !== 32'h304) $display("FAIL jalr_same_link_push got %h exp %h", ras_if.address_out, 32'h304); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] exp_top;
`ifdef RAS_TOP_RESTORE_EN
        exp_top = 32'h104;
`else
        exp_top = 32'h304;
`endif
        do_reset();
        jump(1'b0, 32'h100, 5'd1, 5'd0); ras_if.ckpt_alloc = 1'b1; step(); idle();
        total++; if (ras_if.ckpt_id !== 2'd1) $display("FAIL flush_alloc_id got %0d exp 1", ras_if.ckpt_id); else passed++;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step();
        jump(1'b0, 32'h300, 5'd1, 5'd0); step(); idle();
        total++; if (ras_if.address_out !== 32'h304) $display("FAIL flush_wrong_path got %h exp %h", ras_if.address_out, 32'h304); else passed++;
        ras_if.flush_valid = 1'b1; ras_if.flush_id = 2'd0; step(); idle();
        total++; if (ras_if.address_out !== exp_top) $display("FAIL flush_top got %h exp %h", ras_if.address_out, exp_top); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd1) $display("FAIL flush_ckpt_id got %0d exp 1", ras_if.ckpt_id); else passed++;
        total++; if (ras_if.empty !== 1'b0) $display("FAIL flush_empty got %b exp 0", ras_if.empty); else passed++;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL flush_count got empty %b exp 1", ras_if.empty); else passed++;
    endtask

    task automatic test_ckpt_full();
        do_reset();
        ras_if.ckpt_alloc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle();
        total++; if (ras_if.ckpt_full !== 1'b1) $display("FAIL full_set got %b exp 1", ras_if.ckpt_full); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd0) $display("FAIL full_tail got %0d exp 0", ras_if.ckpt_id); else passed++;
        ras_if.ckpt_alloc = 1'b1; step(); idle();
        total++; if (ras_if.ckpt_id !== 2'd0) $display("FAIL full_ignored got %0d exp 0", ras_if.ckpt_id); else passed++;
        ras_if.ckpt_alloc = 1'b1; ras_if.ckpt_release = 1'b1; step(); idle();
        total++; if (ras_if.ckpt_full !== 1'b1) $display("FAIL full_swap got %b exp 1", ras_if.ckpt_full); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd1) $display("FAIL full_swap_tail got %0d exp 1", ras_if.ckpt_id); else passed++;
        ras_if.ckpt_release = 1'b1; step(); idle();
        total++; if (ras_if.ckpt_full !== 1'b0) $display("FAIL release_clear got %b exp 0", ras_if.ckpt_full); else passed++;
    endtask

    task automatic test_flush_drop();
        do_reset();
        ras_if.ckpt_alloc = 1'b1; step(); idle();
        jump(1'b0, 32'h400, 5'd1, 5'd0);
        ras_if.ckpt_alloc = 1'b1; ras_if.flush_valid = 1'b1; ras_if.flush_id = 2'd0;
        step(); idle();
        total++; if (ras_if.empty !== 1'b1) $display("FAIL flush_drop_push got empty %b exp 1", ras_if.empty); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd1) $display("FAIL flush_drop_alloc got %0d exp 1", ras_if.ckpt_id); else passed++;
    endtask

    task automatic test_clk_en();
        do_reset();
        jump(1'b0, 32'h100, 5'd1, 5'd0); ras_if.ckpt_alloc = 1'b1; step(); idle();
        ras_if.clk_en = 1'b0;
        jump(1'b0, 32'h500, 5'd1, 5'd0);
        ras_if.ckpt_alloc = 1'b1; ras_if.ckpt_release = 1'b1;
        step(); step(); idle();
        total++; if (ras_if.address_out !== 32'h104) $display("FAIL clken_addr got %h exp %h", ras_if.address_out, 32'h104); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd1) $display("FAIL clken_ckpt_id got %0d exp 1", ras_if.ckpt_id); else passed++;
        ras_if.clk_en = 1'b0; ras_if.flush_valid = 1'b1; ras_if.flush_id = 2'd0;
        jump(1'b1, 32'h0, 5'd0, 5'd1); step(); idle();
        total++; if (ras_if.empty !== 1'b0) $display("FAIL clken_pop got empty %b exp 0", ras_if.empty); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        jump(1'b0, 32'h100, 5'd1, 5'd0); ras_if.ckpt_alloc = 1'b1; step(); idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (ras_if.address_out !== 32'h0) $display("FAIL async_rst_addr got %h exp %h", ras_if.address_out, 32'h0); else passed++;
        total++; if (ras_if.empty !== 1'b1) $display("FAIL async_rst_empty got %b exp 1", ras_if.empty); else passed++;
        total++; if (ras_if.ckpt_id !== 2'd0) $display("FAIL async_rst_ckpt_id got %0d exp 0", ras_if.ckpt_id); else passed++;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_overflow();
        test_pop_then_push();
        test_flush();
        test_ckpt_full();
        test_flush_drop();
        test_clk_en();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
